// File: rtl/io_intr_pkg.sv
// Shared encodings for the IO interrupt controller: channel FSM states,
// status/command bit positions. Timer is built only with IO_INTR_TIMER_EN.
package io_intr_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } chan_state_e;

  localparam int NUM_CH = 2;

  // status = {4'b0, ovf2, ovf1, pend2, pend1}
  localparam int ST_PEND = 0;
  localparam int ST_OVF  = 2;

  // cpu_cmd: bit c toggles ack for channel c, bit 7 toggles overflow clear
  localparam int CMD_ACK     = 0;
  localparam int CMD_OVF_CLR = 7;

endpackage

// File: rtl/io_intr_ctrl_if.sv
// CPU/event-side signal bundle of io_intr_ctrl.
interface io_intr_ctrl_if;
  logic       ev1;
  logic       ev2;
  logic [7:0] cpu_cmd;
  logic [7:0] cpu_period;
  logic       intr1;
  logic       intr2;
  logic [7:0] status;
  logic [7:0] tcount;

  modport master (
    output ev1, ev2, cpu_cmd, cpu_period,
    input  intr1, intr2, status, tcount
  );

  modport slave (
    input  ev1, ev2, cpu_cmd, cpu_period,
    output intr1, intr2, status, tcount
  );
endinterface

// File: rtl/intr_chan.sv
// One interrupt channel: IDLE/ACTIVE request FSM plus a sticky overflow flag.
module intr_chan
  import io_intr_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic ev,
  input  logic ack,
  input  logic ovf_clr,
  output logic active,
  output logic ovf
);

  chan_state_e state, state_nxt;
  logic        ovf_nxt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      ovf   <= ovf_nxt;
    end
  end

  // An overflow set in the same cycle as a clear takes precedence.
  always_comb begin
    state_nxt = state;
    ovf_nxt   = ovf;
    if (ovf_clr) ovf_nxt = 1'b0;
    case (state)
      IDLE:    if (ev) state_nxt = ACTIVE;
      ACTIVE: begin
        if (ack && !ev)      state_nxt = IDLE;
        else if (ev && !ack) ovf_nxt   = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign active = (state == ACTIVE);

endmodule

// File: rtl/io_intr_ctrl.sv
// Two-channel interrupt controller with edge-detected events, toggle acks,
// sticky overflow flags and an optional period timer (IO_INTR_TIMER_EN).
module io_intr_ctrl
  import io_intr_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  io_intr_ctrl_if.slave  bus
);

  logic [NUM_CH-1:0] ev_in, ev_q, ack_q, ack, chan_ev, active, ovf;
  logic              clr_q, clr, tmr_ev;
  logic [7:0]        count;

  assign ev_in = {bus.ev2, bus.ev1};

  // History keeps sampling through reset so nothing fires on release.
  always_ff @(posedge clk) begin
    ev_q  <= ev_in;
    ack_q <= bus.cpu_cmd[CMD_ACK +: NUM_CH];
    clr_q <= bus.cpu_cmd[CMD_OVF_CLR];
  end

  assign ack = bus.cpu_cmd[CMD_ACK +: NUM_CH] ^ ack_q;
  assign clr = bus.cpu_cmd[CMD_OVF_CLR] ^ clr_q;

`ifdef IO_INTR_TIMER_EN
  // A new period is only picked up when the count reloads.
  always_ff @(posedge clk) begin
    if (!reset || bus.cpu_period == 8'd0) count <= 8'd0;
    else if (count <= 8'd1)               count <= bus.cpu_period;
    else                                  count <= count - 8'd1;
  end

  assign tmr_ev = (bus.cpu_period != 8'd0) && (count == 8'd1);
`else
  assign count  = 8'd0;
  assign tmr_ev = 1'b0;
`endif

  // Timer tick merges into channel 2; a coincident ev2 edge is one event.
  assign chan_ev = (ev_in & ~ev_q) | {tmr_ev, {(NUM_CH-1){1'b0}}};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    intr_chan u_chan (
      .clk     (clk),
      .reset   (reset),
      .ev      (chan_ev[c]),
      .ack     (ack[c]),
      .ovf_clr (clr),
      .active  (active[c]),
      .ovf     (ovf[c])
    );
  end

  always_comb begin
    bus.status                      = 8'd0;
    bus.status[ST_PEND +: NUM_CH]   = active;
    bus.status[ST_OVF  +: NUM_CH]   = ovf;
  end

  assign bus.intr1  = active[0];
  assign bus.intr2  = active[1];
  assign bus.tcount = count;

endmodule

// File: tb/tb_io_intr_ctrl.sv
// Randomized + directed bench for io_intr_ctrl with a scoreboard queue.
module tb_io_intr_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  io_intr_ctrl_if bif ();

  io_intr_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  typedef struct {
    logic       i1;
    logic       i2;
    logic [7:0] st;
    logic [7:0] tc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: what the CPU would observe.
  bit       pend [2];
  bit       oflag[2];
  bit       last_ev[2];
  bit [7:0] last_cmd;
  int       tcnt;

  bit       cur_e1, cur_e2;
  bit [7:0] cur_cmd, cur_per;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, want, $time);
    end
  endtask

  // Applies one cycle of inputs and predicts the outputs after the next edge.
  task automatic step(input bit rst_n);
    bit   evt[2];
    bit   acked[2];
    bit   wipe, tick;
    exp_t e;
    @(negedge clk);
    reset          = rst_n;
    bif.ev1        = cur_e1;
    bif.ev2        = cur_e2;
    bif.cpu_cmd    = cur_cmd;
    bif.cpu_period = cur_per;
    if (!rst_n) begin
      pend  = '{0, 0};
      oflag = '{0, 0};
      tcnt  = 0;
    end else begin
      evt[0] = cur_e1 && !last_ev[0];
      evt[1] = cur_e2 && !last_ev[1];
      tick   = 1'b0;
`ifdef IO_INTR_TIMER_EN
      tick = (cur_per != 0) && (tcnt == 1);
      if (cur_per == 0)   tcnt = 0;
      else if (tcnt < 2)  tcnt = cur_per;
      else                tcnt = tcnt - 1;
`endif
      evt[1]   = evt[1] || tick;
      acked[0] = cur_cmd[0] != last_cmd[0];
      acked[1] = cur_cmd[1] != last_cmd[1];
      wipe     = cur_cmd[7] != last_cmd[7];
      for (int c = 0; c < 2; c++) begin
        bit lost;
        lost = pend[c] && evt[c] && !acked[c];
        if (!pend[c])                pend[c] = evt[c];
        else if (acked[c] && !evt[c]) pend[c] = 0;
        if (lost)       oflag[c] = 1;
        else if (wipe)  oflag[c] = 0;
      end
    end
    last_ev[0] = cur_e1;
    last_ev[1] = cur_e2;
    last_cmd   = cur_cmd;
    e.i1 = pend[0];
    e.i2 = pend[1];
    e.st = {4'b0, oflag[1], oflag[0], pend[1], pend[0]};
    e.tc = 8'(tcnt);
    exp_q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1);
  endtask

  // Monitor: compare each predicted cycle just after the edge it describes.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("intr1",  {7'b0, bif.intr1}, {7'b0, e.i1});
        chk("intr2",  {7'b0, bif.intr2}, {7'b0, e.i2});
        chk("status", bif.status, e.st);
        chk("tcount", bif.tcount, e.tc);
      end
    end
  end

  initial begin
    reset = 1'b0;
    bif.ev1 = 1'b0; bif.ev2 = 1'b0; bif.cpu_cmd = 8'h00; bif.cpu_period = 8'h00;
    cur_e1 = 0; cur_e2 = 0; cur_cmd = 8'h00; cur_per = 8'h00;

    // Reset, then ev1 rise, then ack via bit0 toggle
    repeat (3) step(1'b0);
    run(4);
    cur_e1 = 1; run(5);
    cur_cmd ^= 8'h01; run(3);
    cur_e1 = 0; run(2);

    // Two ev2 edges without ack -> overflow, then clear via bit7
    cur_e2 = 1; step(1); cur_e2 = 0; run(2);
    cur_e2 = 1; run(3);
    cur_cmd ^= 8'h80; run(2);
    cur_cmd ^= 8'h02; run(2);
    cur_e2 = 0; run(1);

    // Event and ack coincide while active
    cur_e1 = 1; run(2); cur_e1 = 0; run(1);
    cur_e1 = 1; cur_cmd ^= 8'h01; run(2);
    cur_cmd ^= 8'h01; run(2);
    cur_e1 = 0; run(1);

    // Overflow set and clear in the same cycle
    cur_e1 = 1; run(2); cur_e1 = 0; run(1);
    cur_e1 = 1; cur_cmd ^= 8'h80; run(2);
    cur_cmd ^= 8'h81; run(2);
    cur_e1 = 0;

    // Timer: period 4, then 1, then off
    cur_per = 8'd4; run(12);
    cur_cmd ^= 8'h02; run(3);
    cur_per = 8'd1; run(4);
    cur_per = 8'd0; run(3);
    cur_cmd ^= 8'h82; run(2);

    // Ack on idle channel, then reset with intr1 set and ev1 held high
    cur_cmd ^= 8'h02; run(2);
    cur_e1 = 1; run(3);
    step(1'b0); step(1'b0);
    run(4);
    cur_e1 = 0; run(2);

    // Random traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 3) == 0) cur_e1 = !cur_e1;
      if ($urandom_range(0, 3) == 0) cur_e2 = !cur_e2;
      if ($urandom_range(0, 4) == 0) cur_cmd ^= 8'h01;
      if ($urandom_range(0, 4) == 0) cur_cmd ^= 8'h02;
      if ($urandom_range(0, 9) == 0) cur_cmd ^= 8'h80;
      if ($urandom_range(0, 7) == 0) cur_cmd ^= 8'(($urandom_range(0, 31)) << 2);
      if ($urandom_range(0, 60) == 0) begin
        case ($urandom_range(0, 5))
          0: cur_per = 8'd0;
          1: cur_per = 8'd1;
          2: cur_per = 8'd2;
          3: cur_per = 8'd3;
          4: cur_per = 8'd4;
          default: cur_per = 8'($urandom_range(0, 255));
        endcase
      end
      step(($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1);
    end

    repeat (3) @(posedge clk);
    #2;
    chk("drain", 8'(exp_q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
